// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared opcodes, ALU controls and pipeline payload types
package riscv_pkg;

  localparam logic [6:0] OP_R   = 7'h33;
  localparam logic [6:0] OP_I   = 7'h13;
  localparam logic [6:0] OP_LW  = 7'h03;
  localparam logic [6:0] OP_SW  = 7'h23;
  localparam logic [6:0] OP_BEQ = 7'h63;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_WB   = 2'd1,
    FWD_MEM  = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    alu_ctrl_e   alu_ctrl;
    logic        alu_src;
    logic        reg_write;
    logic        mem_write;
    logic        mem_to_reg;
    logic        branch;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_write;
    logic        mem_to_reg;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_to_reg;
  } mem_wb_t;

  // Every non-store, non-branch opcode takes the I-format immediate.
  function automatic logic [31:0] imm_gen(input logic [31:0] instr);
    case (instr[6:0])
      OP_SW:   imm_gen = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OP_BEQ:  imm_gen = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      default: imm_gen = {{20{instr[31]}}, instr[31:20]};
    endcase
  endfunction

endpackage

// File: rtl/riscv_alu.sv
// rtl/riscv_alu.sv - 32-bit ALU with zero flag
module riscv_alu import riscv_pkg::*; (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_ctrl_e   ctrl,
  output logic [31:0] result,
  output logic        zero
);

  always_comb begin
    case (ctrl)
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {31'b0, ($signed(a) < $signed(b))};
      default: result = a + b;
    endcase
  end

  assign zero = (result == 32'd0);

endmodule

// File: rtl/riscv_dmem.sv
// rtl/riscv_dmem.sv - word data memory, async read, write on rising edge, no reset
module riscv_dmem #(
  parameter int WORDS = 256,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/riscv_hazard_unit.sv
// rtl/riscv_hazard_unit.sv - operand forwarding select, load-use stall and branch flush
module riscv_hazard_unit import riscv_pkg::*; (
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] ex_rs1,
  input  logic [4:0] ex_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_to_reg,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_rd,
  input  logic       wb_reg_write,
  input  logic       branch_taken,
  output fwd_sel_e   fwd_a,
  output fwd_sel_e   fwd_b,
  output logic       stall,
  output logic       flush
);

  logic load_use;

  always_comb begin
    fwd_a = FWD_NONE;
    if (mem_reg_write && mem_rd != 5'd0 && mem_rd == ex_rs1) fwd_a = FWD_MEM;
    else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_rs1) fwd_a = FWD_WB;
    fwd_b = FWD_NONE;
    if (mem_reg_write && mem_rd != 5'd0 && mem_rd == ex_rs2) fwd_b = FWD_MEM;
    else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_rs2) fwd_b = FWD_WB;
  end

  // Only lw sets mem_to_reg, so it marks a load sitting in EX.
  assign load_use = ex_mem_to_reg && ex_rd != 5'd0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
  assign flush    = branch_taken;
  assign stall    = load_use && !branch_taken;

endmodule

// File: rtl/riscv_imem.sv
// rtl/riscv_imem.sv - instruction ROM built from a packed image parameter, async read
module riscv_imem #(
  parameter int                     WORDS = 256,
  parameter int                     AW    = $clog2(WORDS),
  parameter logic [WORDS*32-1:0]    INIT  = '0
) (
  input  logic [AW-1:0] addr,
  output logic [31:0]   instr
);

  logic [31:0] mem [WORDS];

  for (genvar i = 0; i < WORDS; i++) begin : g_rom
    assign mem[i] = INIT[i*32 +: 32];
  end

  assign instr = mem[addr];

endmodule

// File: rtl/riscv_regfile.sv
// rtl/riscv_regfile.sv - 32x32 GPR file, two async read ports, write-through on the WB port
module riscv_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] regs [32];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && wa != 5'd0) begin
      regs[wa] <= wd;
    end
  end

  always_comb begin
    rd1 = regs[ra1];
    if (ra1 == 5'd0) rd1 = '0;
    else if (we && wa == ra1) rd1 = wd;
    rd2 = regs[ra2];
    if (ra2 == 5'd0) rd2 = '0;
    else if (we && wa == ra2) rd2 = wd;
  end

endmodule

// File: rtl/riscv_pipeline_top.sv
// rtl/riscv_pipeline_top.sv - five-stage in-order RV32I-subset core with preloaded IMEM
module riscv_pipeline_top import riscv_pkg::*; #(
  parameter int                       IMEM_WORDS = 256,
  parameter int                       DMEM_WORDS = 256,
  parameter logic [IMEM_WORDS*32-1:0] IMEM_INIT  = '0
) (
  input logic clk,
  input logic rst
);

  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  logic [31:0] pc_q, pc_d;
  if_id_t      if_id_q, if_id_d;
  id_ex_t      id_ex_q, id_ex_d, id_dec;
  ex_mem_t     ex_mem_q, ex_mem_d;
  mem_wb_t     mem_wb_q, mem_wb_d;

  logic [31:0] imem_instr, rf_rd1, rf_rd2, dmem_rdata, wb_data;
  logic [31:0] fwd_a_val, fwd_b_val, alu_b, alu_result, branch_target;
  logic        alu_zero, branch_taken, stall, flush;
  fwd_sel_e    fwd_a, fwd_b;

  riscv_imem #(.WORDS(IMEM_WORDS), .AW(IAW), .INIT(IMEM_INIT)) u_imem (
    .addr  (pc_q[IAW+1:2]),
    .instr (imem_instr)
  );

  riscv_regfile u_regfile (
    .clk (clk),
    .rst (rst),
    .ra1 (if_id_q.instr[19:15]),
    .ra2 (if_id_q.instr[24:20]),
    .rd1 (rf_rd1),
    .rd2 (rf_rd2),
    .we  (mem_wb_q.reg_write),
    .wa  (mem_wb_q.rd),
    .wd  (wb_data)
  );

  always_comb begin
    id_dec          = '0;
    id_dec.pc       = if_id_q.pc;
    id_dec.rd1      = rf_rd1;
    id_dec.rd2      = rf_rd2;
    id_dec.imm      = imm_gen(if_id_q.instr);
    id_dec.rs1      = if_id_q.instr[19:15];
    id_dec.rs2      = if_id_q.instr[24:20];
    id_dec.rd       = if_id_q.instr[11:7];
    case (if_id_q.instr[6:0])
      OP_R: begin
        id_dec.reg_write = 1'b1;
        case (if_id_q.instr[14:12])
          3'b000:  id_dec.alu_ctrl = if_id_q.instr[30] ? ALU_SUB : ALU_ADD;
          3'b111:  id_dec.alu_ctrl = ALU_AND;
          3'b110:  id_dec.alu_ctrl = ALU_OR;
          3'b010:  id_dec.alu_ctrl = ALU_SLT;
          default: id_dec.reg_write = 1'b0;
        endcase
      end
      OP_I: begin
        id_dec.reg_write = 1'b1;
        id_dec.alu_src   = 1'b1;
        case (if_id_q.instr[14:12])
          3'b000:  id_dec.alu_ctrl = ALU_ADD;
          3'b111:  id_dec.alu_ctrl = ALU_AND;
          3'b110:  id_dec.alu_ctrl = ALU_OR;
          3'b010:  id_dec.alu_ctrl = ALU_SLT;
          default: id_dec.reg_write = 1'b0;
        endcase
      end
      OP_LW: begin
        id_dec.reg_write  = 1'b1;
        id_dec.alu_src    = 1'b1;
        id_dec.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        id_dec.alu_src   = 1'b1;
        id_dec.mem_write = 1'b1;
      end
      OP_BEQ: begin
        id_dec.branch   = 1'b1;
        id_dec.alu_ctrl = ALU_SUB;
      end
      default: ;
    endcase
  end

  riscv_hazard_unit u_hazard (
    .id_rs1        (if_id_q.instr[19:15]),
    .id_rs2        (if_id_q.instr[24:20]),
    .ex_rs1        (id_ex_q.rs1),
    .ex_rs2        (id_ex_q.rs2),
    .ex_rd         (id_ex_q.rd),
    .ex_mem_to_reg (id_ex_q.mem_to_reg),
    .mem_rd        (ex_mem_q.rd),
    .mem_reg_write (ex_mem_q.reg_write),
    .wb_rd         (mem_wb_q.rd),
    .wb_reg_write  (mem_wb_q.reg_write),
    .branch_taken  (branch_taken),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b),
    .stall         (stall),
    .flush         (flush)
  );

  always_comb begin
    case (fwd_a)
      FWD_MEM: fwd_a_val = ex_mem_q.alu_result;
      FWD_WB:  fwd_a_val = wb_data;
      default: fwd_a_val = id_ex_q.rd1;
    endcase
    case (fwd_b)
      FWD_MEM: fwd_b_val = ex_mem_q.alu_result;
      FWD_WB:  fwd_b_val = wb_data;
      default: fwd_b_val = id_ex_q.rd2;
    endcase
    alu_b = id_ex_q.alu_src ? id_ex_q.imm : fwd_b_val;
  end

  riscv_alu u_alu (
    .a      (fwd_a_val),
    .b      (alu_b),
    .ctrl   (id_ex_q.alu_ctrl),
    .result (alu_result),
    .zero   (alu_zero)
  );

  assign branch_taken  = id_ex_q.branch && alu_zero;
  assign branch_target = id_ex_q.pc + id_ex_q.imm;

  riscv_dmem #(.WORDS(DMEM_WORDS), .AW(DAW)) u_dmem (
    .clk   (clk),
    .we    (ex_mem_q.mem_write),
    .addr  (ex_mem_q.alu_result[DAW+1:2]),
    .wdata (ex_mem_q.write_data),
    .rdata (dmem_rdata)
  );

  assign wb_data = mem_wb_q.mem_to_reg ? mem_wb_q.read_data : mem_wb_q.alu_result;

  // A taken branch outranks a load-use stall on the front end.
  always_comb begin
    pc_d           = pc_q + 32'd4;
    if_id_d.pc     = pc_q;
    if_id_d.instr  = imem_instr;
    id_ex_d        = id_dec;
    if (flush) begin
      pc_d    = branch_target;
      if_id_d = '0;
      id_ex_d = '0;
    end else if (stall) begin
      pc_d    = pc_q;
      if_id_d = if_id_q;
      id_ex_d = '0;
    end
  end

  always_comb begin
    ex_mem_d.alu_result = alu_result;
    ex_mem_d.write_data = fwd_b_val;
    ex_mem_d.rd         = id_ex_q.rd;
    ex_mem_d.reg_write  = id_ex_q.reg_write;
    ex_mem_d.mem_write  = id_ex_q.mem_write;
    ex_mem_d.mem_to_reg = id_ex_q.mem_to_reg;
    mem_wb_d.alu_result = ex_mem_q.alu_result;
    mem_wb_d.read_data  = dmem_rdata;
    mem_wb_d.rd         = ex_mem_q.rd;
    mem_wb_d.reg_write  = ex_mem_q.reg_write;
    mem_wb_d.mem_to_reg = ex_mem_q.mem_to_reg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= '0;
      if_id_q  <= '0;
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      pc_q     <= pc_d;
      if_id_q  <= if_id_d;
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

endmodule

// File: tb/tb_riscv_pipeline_top.sv
// tb/tb_riscv_pipeline_top.sv - directed program checks for the five-stage core
module tb_riscv_pipeline_top;

  localparam int WORDS = 256;

  function automatic logic [31:0] r_type(input int f7, input int rs2, input int rs1, input int f3, input int rd);
    logic [31:0] a7, a2, a1, a3, ad;
    a7 = f7; a2 = rs2; a1 = rs1; a3 = f3; ad = rd;
    return {a7[6:0], a2[4:0], a1[4:0], a3[2:0], ad[4:0], 7'h33};
  endfunction

  function automatic logic [31:0] i_type(input int imm, input int rs1, input int f3, input int rd, input int op);
    logic [31:0] v, a1, a3, ad, ao;
    v = imm; a1 = rs1; a3 = f3; ad = rd; ao = op;
    return {v[11:0], a1[4:0], a3[2:0], ad[4:0], ao[6:0]};
  endfunction

  function automatic logic [31:0] s_type(input int imm, input int rs2, input int rs1);
    logic [31:0] v, a2, a1;
    v = imm; a2 = rs2; a1 = rs1;
    return {v[11:5], a2[4:0], a1[4:0], 3'b010, v[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] b_type(input int imm, input int rs2, input int rs1);
    logic [31:0] v, a2, a1;
    v = imm; a2 = rs2; a1 = rs1;
    return {v[12], v[10:5], a2[4:0], a1[4:0], 3'b000, v[4:1], v[11], 7'h63};
  endfunction

  function automatic logic [31:0] prog_word(input int i);
    case (i)
      0:  return i_type(5, 0, 0, 1, 'h13);        // addi x1,x0,5
      1:  return i_type(7, 0, 0, 2, 'h13);        // addi x2,x0,7
      2:  return r_type(0, 2, 1, 0, 3);           // add x3,x1,x2
      3:  return i_type(16, 0, 0, 1, 'h13);       // addi x1,x0,16
      4:  return s_type(4, 1, 0);                 // sw x1,4(x0)
      5:  return i_type(4, 0, 2, 4, 'h03);        // lw x4,4(x0)
      6:  return r_type(0, 4, 4, 0, 5);           // add x5,x4,x4
      7:  return i_type(1, 0, 0, 1, 'h13);        // addi x1,x0,1
      8:  return b_type(8, 1, 1);                 // beq x1,x1,+8
      9:  return i_type(99, 0, 0, 6, 'h13);       // addi x6,x0,99
      10: return i_type(3, 0, 0, 7, 'h13);        // addi x7,x0,3
      11: return i_type(5, 0, 0, 1, 'h13);        // addi x1,x0,5
      12: return r_type('h20, 1, 0, 0, 8);        // sub x8,x0,x1
      13: return r_type(0, 0, 8, 2, 9);           // slt x9,x8,x0
      14: return i_type(9, 0, 0, 0, 'h13);        // addi x0,x0,9
      15: return i_type(1, 0, 0, 19, 'h13);       // addi x19,x0,1
      16: return 32'h00A0057F;                    // opcode 0x7F, rd=x10
      17: return r_type(0, 5, 3, 6, 12);          // or x12,x3,x5
      18: return r_type(0, 3, 2, 7, 14);          // and x14,x2,x3
      19: return i_type(13, 3, 7, 13, 'h13);      // andi x13,x3,13
      20: return i_type(8, 2, 6, 15, 'h13);       // ori x15,x2,8
      21: return i_type(-4, 8, 2, 16, 'h13);      // slti x16,x8,-4
      22: return b_type(8, 2, 1);                 // beq x1,x2,+8 (not taken)
      23: return i_type(21, 0, 0, 18, 'h13);      // addi x18,x0,21
      24: return s_type(-4, 12, 0);               // sw x12,-4(x0)
      25: return s_type(10, 14, 0);               // sw x14,10(x0)
      26: return b_type(0, 0, 0);                 // beq x0,x0,0 (halt)
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [WORDS*32-1:0] build_prog();
    logic [WORDS*32-1:0] p;
    p = '0;
    for (int i = 0; i < 27; i++) p[i*32 +: 32] = prog_word(i);
    return p;
  endfunction

  localparam logic [WORDS*32-1:0] PROG = build_prog();

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  int   stall_cnt;

  riscv_pipeline_top #(.IMEM_WORDS(WORDS), .DMEM_WORDS(WORDS), .IMEM_INIT(PROG)) dut (
    .clk (clk),
    .rst (rst)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  always @(negedge clk) begin
    if (rst === 1'b1 && dut.u_hazard.stall === 1'b1) stall_cnt++;
  end

  task automatic run_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #170;
    n_checks++;
    if (dut.pc_q !== 32'h0) $display("FAIL reset_pc: got %h expected 00000000", dut.pc_q);
    else n_pass++;
    n_checks++;
    if (dut.if_id_q !== '0) $display("FAIL reset_if_id: got %h expected 0", dut.if_id_q);
    else n_pass++;
    n_checks++;
    if (dut.id_ex_q !== '0) $display("FAIL reset_id_ex: got %h expected 0", dut.id_ex_q);
    else n_pass++;
    n_checks++;
    if (dut.ex_mem_q !== '0) $display("FAIL reset_ex_mem: got %h expected 0", dut.ex_mem_q);
    else n_pass++;
    n_checks++;
    if (dut.mem_wb_q !== '0) $display("FAIL reset_mem_wb: got %h expected 0", dut.mem_wb_q);
    else n_pass++;
    for (int r = 0; r < 32; r++) begin
      n_checks++;
      if (dut.u_regfile.regs[r] !== 32'h0)
        $display("FAIL reset_x%0d: got %h expected 00000000", r, dut.u_regfile.regs[r]);
      else n_pass++;
    end
  endtask

  task automatic test_reg_table(input string name, input int regs_idx[], input logic [31:0] exp[]);
    for (int k = 0; k < regs_idx.size(); k++) begin
      n_checks++;
      if (dut.u_regfile.regs[regs_idx[k]] !== exp[k])
        $display("FAIL %s_x%0d: got %h expected %h", name, regs_idx[k], dut.u_regfile.regs[regs_idx[k]], exp[k]);
      else n_pass++;
    end
  endtask

  task automatic test_alu_forward();
    test_reg_table("fwd", '{2, 3}, '{32'd7, 32'd12});
  endtask

  task automatic test_load_use();
    n_checks++;
    if (dut.u_dmem.mem[1] !== 32'd16) $display("FAIL lu_dmem1: got %h expected 00000010", dut.u_dmem.mem[1]);
    else n_pass++;
    test_reg_table("lu", '{4, 5}, '{32'd16, 32'd32});
    n_checks++;
    if (stall_cnt !== 1) $display("FAIL lu_stall_cycles: got %0d expected 1", stall_cnt);
    else n_pass++;
  endtask

  task automatic test_branch();
    test_reg_table("br", '{6, 7, 18}, '{32'd0, 32'd3, 32'd21});
  endtask

  task automatic test_signed();
    test_reg_table("sgn", '{1, 8, 9, 16}, '{32'd5, 32'hFFFFFFFB, 32'd1, 32'd1});
  endtask

  task automatic test_x0_nop();
    test_reg_table("x0nop", '{0, 19, 10}, '{32'd0, 32'd1, 32'd0});
  endtask

  task automatic test_logic();
    test_reg_table("logic", '{12, 14, 13, 15}, '{32'd44, 32'd4, 32'd12, 32'd15});
  endtask

  task automatic test_mem_boundary();
    n_checks++;
    if (dut.u_dmem.mem[255] !== 32'd44) $display("FAIL mem_wrap255: got %h expected 0000002c", dut.u_dmem.mem[255]);
    else n_pass++;
    n_checks++;
    if (dut.u_dmem.mem[2] !== 32'd4) $display("FAIL mem_unaligned2: got %h expected 00000004", dut.u_dmem.mem[2]);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    logic [31:0] w0;
    w0 = prog_word(0);
    @(posedge clk);
    #20;
    rst = 1'b0;
    #1;
    n_checks++;
    if (dut.pc_q !== 32'h0) $display("FAIL mid_rst_pc: got %h expected 00000000", dut.pc_q);
    else n_pass++;
    n_checks++;
    if (dut.id_ex_q !== '0) $display("FAIL mid_rst_id_ex: got %h expected 0", dut.id_ex_q);
    else n_pass++;
    for (int r = 1; r < 32; r++) begin
      n_checks++;
      if (dut.u_regfile.regs[r] !== 32'h0)
        $display("FAIL mid_rst_x%0d: got %h expected 00000000", r, dut.u_regfile.regs[r]);
      else n_pass++;
    end
    @(negedge clk);
    rst = 1'b1;
    run_cycles(1);
    n_checks++;
    if (dut.pc_q !== 32'h4) $display("FAIL restart_pc: got %h expected 00000004", dut.pc_q);
    else n_pass++;
    n_checks++;
    if (dut.if_id_q.instr !== w0) $display("FAIL restart_if_id: got %h expected %h", dut.if_id_q.instr, w0);
    else n_pass++;
    run_cycles(5);
    test_reg_table("restart6", '{1, 2, 3}, '{32'd5, 32'd7, 32'd0});
    run_cycles(1);
    test_reg_table("restart7", '{3}, '{32'd12});
    #20;
    rst = 1'b0;
    #1;
    test_reg_table("rst_again", '{1, 3}, '{32'd0, 32'd0});
    n_checks++;
    if (dut.pc_q !== 32'h0) $display("FAIL rst_again_pc: got %h expected 00000000", dut.pc_q);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    run_cycles(80);
    test_reg_table("rerun", '{5, 7, 12, 18}, '{32'd32, 32'd3, 32'd44, 32'd21});
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    stall_cnt = 0;
    rst       = 1'b0;
    test_reset();
    #30;
    rst = 1'b1;
    run_cycles(80);
    test_alu_forward();
    test_load_use();
    test_branch();
    test_signed();
    test_x0_nop();
    test_logic();
    test_mem_boundary();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
